// File: rtl/piso8_sequencer.sv
// piso8_sequencer
// Parallel-in/serial-out sequencer feeding a downstream 8:1 mux.
// It accepts a byte over a valid/ready handshake and holds it stable on
// hold_data. It then steps the 3-bit mux select once per shift_en cycle and
// flags the first and last bit of each word.
// A new word can be accepted on the same cycle the last bit is consumed, so
// a continuously fed stream runs at one bit per enabled cycle with no bubble.

module piso8_sequencer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       shift_en,
    output logic [7:0] hold_data,
    output logic [2:0] sel,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_first,
    output logic       ser_last,
    output logic       busy,
    output logic [7:0] word_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Select index of the first and last presented bit for the chosen order.
    localparam logic [2:0] START_SEL = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] END_SEL   = MSB_FIRST ? 3'd0 : 3'd7;

    state_t     state_reg, state_next;
    logic [7:0] hold_reg,  hold_next;
    logic [2:0] sel_reg,   sel_next;
    logic [7:0] cnt_reg,   cnt_next;

    logic       shifting;
    logic       last_bit;
    logic       accept;
    logic [2:0] sel_step;
    logic [7:0] bit_match;

    assign shifting = (state_reg == SHIFT);
    assign last_bit = shifting & (sel_reg == END_SEL);

    // Ready in IDLE, or when the final bit is being consumed this cycle.
    assign in_ready = ~shifting | (last_bit & shift_en);
    assign accept   = in_valid & in_ready;

    assign sel_step = MSB_FIRST ? (sel_reg - 3'd1) : (sel_reg + 3'd1);

    // One-hot pick of the held bit addressed by sel. This mirrors the
    // downstream mux, so ser_out matches what the mux presents.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit_pick
            assign bit_match[gi] = hold_reg[gi] & (sel_reg == 3'(gi));
        end
    endgenerate

    assign ser_out   = shifting & (|bit_match);
    assign ser_valid = shifting;
    assign busy      = shifting;
    assign ser_first = shifting & (sel_reg == START_SEL);
    assign ser_last  = last_bit;

    assign hold_data = hold_reg;
    assign sel       = sel_reg;
    assign word_cnt  = cnt_reg;

    // Next-state: load on accept, step the select on enable, count finished words.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    hold_next  = in_data;
                    sel_next   = START_SEL;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (last_bit) begin
                        cnt_next = cnt_reg + 8'd1;
                        if (accept) begin
                            // Back-to-back reload: stay in SHIFT with no bubble.
                            hold_next = in_data;
                            sel_next  = START_SEL;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        sel_next = sel_step;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers; reset aborts any word in flight and clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            hold_reg  <= 8'd0;
            sel_reg   <= 3'd0;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            sel_reg   <= sel_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_piso8_sequencer.sv
// Directed testbench for piso8_sequencer (LSB-first and MSB-first instances).
module tb_piso8_sequencer;

    logic       clk;
    logic       rst_n;

    // LSB-first instance signals
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       shift_en;
    logic [7:0] hold_data;
    logic [2:0] sel;
    logic       ser_out, ser_valid, ser_first, ser_last, busy;
    logic [7:0] word_cnt;

    // MSB-first instance signals
    logic [7:0] m_in_data;
    logic       m_in_valid;
    logic       m_in_ready;
    logic       m_shift_en;
    logic [7:0] m_hold_data;
    logic [2:0] m_sel;
    logic       m_ser_out, m_ser_valid, m_ser_first, m_ser_last, m_busy;
    logic [7:0] m_word_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt;

    piso8_sequencer #(.MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .hold_data (hold_data),
        .sel       (sel),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    piso8_sequencer #(.MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (m_in_data),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .shift_en  (m_shift_en),
        .hold_data (m_hold_data),
        .sel       (m_sel),
        .ser_out   (m_ser_out),
        .ser_valid (m_ser_valid),
        .ser_first (m_ser_first),
        .ser_last  (m_ser_last),
        .busy      (m_busy),
        .word_cnt  (m_word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial bit must always equal the held bit addressed by sel.
    always @(negedge clk) begin
        if (rst_n && ser_valid)
            check("inv_lsb", ser_out, hold_data[sel]);
        if (rst_n && m_ser_valid)
            check("inv_msb", m_ser_out, m_hold_data[m_sel]);
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Checks for one presented bit of the LSB-first instance.
    task automatic check_bit(input string tag, input int idx, input logic [7:0] w,
                             input logic exp_ready);
        check({tag, "_sel"},   sel, idx);
        check({tag, "_valid"}, ser_valid, 1'b1);
        check({tag, "_busy"},  busy, 1'b1);
        check({tag, "_bit"},   ser_out, w[idx]);
        check({tag, "_first"}, ser_first, idx == 0);
        check({tag, "_last"},  ser_last, idx == 7);
        check({tag, "_ready"}, in_ready, exp_ready);
        check({tag, "_hold"},  hold_data, w);
    endtask

    // Send one word through the LSB instance; entered at posedge+1 with DUT idle.
    task automatic send_word(input string tag, input logic [7:0] w, input bit stall);
        in_data  = w;
        in_valid = 1'b1;
        shift_en = 1'b1;
        #1;
        check({tag, "_idle_ready"}, in_ready, 1'b1);
        check({tag, "_idle_valid"}, ser_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~w;   // must not disturb the held word
        for (int i = 0; i < 8; i++) begin
            if (stall) begin
                shift_en = 1'b0;
                #1;
                check_bit({tag, "_stall"}, i, w, 1'b0);
                @(posedge clk); #1;
            end
            shift_en = 1'b1;
            #1;
            check_bit(tag, i, w, i == 7);
            @(posedge clk); #1;
        end
        exp_cnt = exp_cnt + 8'd1;
        check({tag, "_done_valid"}, ser_valid, 1'b0);
        check({tag, "_done_cnt"}, word_cnt, exp_cnt);
        $display("word %s data=%02h stall=%0d word_cnt=%0d", tag, w, stall, word_cnt);
    endtask

    initial begin
        logic [7:0] w;
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        shift_en   = 1'b0;
        m_in_data  = 8'h00;
        m_in_valid = 1'b0;
        m_shift_en = 1'b0;
        exp_cnt    = 8'd0;

        // Reset state
        #2;
        check("rst_sel", sel, 3'd0);
        check("rst_hold", hold_data, 8'h00);
        check("rst_cnt", word_cnt, 8'h00);
        check("rst_out", ser_out, 1'b0);
        check("rst_valid", ser_valid, 1'b0);
        check("rst_first", ser_first, 1'b0);
        check("rst_last", ser_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_msb_sel", m_sel, 3'd0);
        check("rst_msb_valid", m_ser_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LSB-first A5
        send_word("lsb_a5", 8'hA5, 1'b0);

        // MSB-first 81
        w = 8'h81;
        m_in_data  = w;
        m_in_valid = 1'b1;
        m_shift_en = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        m_in_data  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("msb_sel", m_sel, 7 - i);
            check("msb_bit", m_ser_out, w[7 - i]);
            check("msb_first", m_ser_first, i == 0);
            check("msb_last", m_ser_last, i == 7);
            check("msb_ready", m_in_ready, i == 7);
            @(posedge clk); #1;
        end
        check("msb_done_valid", m_ser_valid, 1'b0);
        check("msb_done_cnt", m_word_cnt, 8'd1);
        $display("word msb_81 data=%02h word_cnt=%0d", w, m_word_cnt);

        // Back-to-back FF then 00
        in_data  = 8'hFF;
        in_valid = 1'b1;
        shift_en = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h00;
        for (int k = 0; k < 16; k++) begin
            w = (k < 8) ? 8'hFF : 8'h00;
            #1;
            check_bit("b2b", k % 8, w, (k % 8) == 7);
            @(posedge clk); #1;
            if (k == 7) in_valid = 1'b0;
        end
        exp_cnt = exp_cnt + 8'd2;
        check("b2b_done_valid", ser_valid, 1'b0);
        check("b2b_done_cnt", word_cnt, exp_cnt);
        $display("word b2b data=ff,00 word_cnt=%0d", word_cnt);

        // Stall with shift_en alternating
        send_word("stall_3c", 8'h3C, 1'b1);

        // Mid-word reset at sel=4
        in_data  = 8'h96;
        in_valid = 1'b1;
        shift_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mid_sel_before", sel, 3'd4);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        check("mid_sel", sel, 3'd0);
        check("mid_hold", hold_data, 8'h00);
        check("mid_out", ser_out, 1'b0);
        check("mid_valid", ser_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_last", ser_last, 1'b0);
        check("mid_cnt", word_cnt, 8'h00);
        check("mid_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        check("mid_no_accept", ser_valid, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        exp_cnt  = 8'd0;
        $display("word mid_reset data=96 aborted at sel=4 word_cnt=%0d", word_cnt);
        send_word("after_rst", 8'h5A, 1'b0);

        // Wrap: 255 more words take the count from 1 to 0
        for (int n = 0; n < 255; n++) begin
            send_word("wrap", 8'($urandom), 1'b0);
        end
        check("wrap_cnt", word_cnt, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
